// File: rtl/redmule_load_sequencer.sv
// Load sequencer: paces X/W row requests for the preload tile and the streamed K-tiles.
// Optional stall counter built only when REDMULE_LDSEQ_PERF_EN is defined.
module redmule_load_sequencer #(
    parameter int unsigned Height      = 4,
    parameter int unsigned NumPipeRegs = 3,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned CntWidth    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 first_load_i,
    input  logic                 sched_rst_i,
    input  logic                 finished_i,
    input  logic [CntWidth-1:0]  n_tiles_i,
    input  logic [AddrWidth-1:0] x_base_i,
    input  logic [AddrWidth-1:0] x_stride_i,
    input  logic [AddrWidth-1:0] w_base_i,
    input  logic [AddrWidth-1:0] w_stride_i,
    output logic                 x_req_valid_o,
    input  logic                 x_req_ready_i,
    output logic [AddrWidth-1:0] x_req_addr_o,
    output logic                 w_req_valid_o,
    input  logic                 w_req_ready_i,
    output logic [AddrWidth-1:0] w_req_addr_o,
    input  logic                 w_rsp_valid_i,
    output logic                 w_loaded_o,
    output logic [CntWidth-1:0]  tile_idx_o,
    output logic                 busy_o,
    output logic [31:0]          stall_cnt_o
);

    localparam int unsigned TILE = (NumPipeRegs + 1) * Height;
    localparam int unsigned CW   = $clog2(TILE + 1);

    localparam logic [CW-1:0] X_LAST   = CW'(Height - 1);
    localparam logic [CW-1:0] W_LAST   = CW'(TILE - 1);
    localparam logic [CW-1:0] TILE_CNT = CW'(TILE);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_X,
        LOAD_W,
        WAIT_W,
        STREAM_X,
        STREAM_W,
        HOLD
    } state_t;

    state_t               state_reg;
    logic [AddrWidth-1:0] x_addr_reg;
    logic [AddrWidth-1:0] w_addr_reg;
    logic [AddrWidth-1:0] x_stride_reg;
    logic [AddrWidth-1:0] w_stride_reg;
    logic [CntWidth-1:0]  n_tiles_reg;
    logic [CntWidth-1:0]  tile_idx_reg;
    logic [CW-1:0]        req_cnt_reg;
    logic [CW-1:0]        rsp_cnt_reg;
    logic                 w_loaded_reg;

    logic                 x_acc;
    logic                 w_acc;
    logic                 rsp_hit;
    logic                 rsp_done;
    logic                 job_end;
    logic [CntWidth-1:0]  tile_inc;

    assign x_req_valid_o = (state_reg == LOAD_X) || (state_reg == STREAM_X);
    assign w_req_valid_o = (state_reg == LOAD_W) || (state_reg == STREAM_W);
    assign x_req_addr_o  = x_addr_reg;
    assign w_req_addr_o  = w_addr_reg;
    assign w_loaded_o    = w_loaded_reg;
    assign tile_idx_o    = tile_idx_reg;
    assign busy_o        = (state_reg != IDLE);

    assign x_acc    = x_req_valid_o && x_req_ready_i;
    assign w_acc    = w_req_valid_o && w_req_ready_i;
    assign tile_inc = tile_idx_reg + CntWidth'(1);
    assign job_end  = (state_reg != IDLE) && (sched_rst_i || finished_i);

    // Responses only matter for the preload tile; the counter saturates at one tile.
    assign rsp_hit  = w_rsp_valid_i && ((state_reg == LOAD_W) || (state_reg == WAIT_W))
                      && (rsp_cnt_reg != TILE_CNT);
    assign rsp_done = (rsp_cnt_reg == TILE_CNT) || ((rsp_cnt_reg == W_LAST) && w_rsp_valid_i);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_reg    <= IDLE;
            x_addr_reg   <= '0;
            w_addr_reg   <= '0;
            x_stride_reg <= '0;
            w_stride_reg <= '0;
            n_tiles_reg  <= '0;
            tile_idx_reg <= '0;
            req_cnt_reg  <= '0;
            rsp_cnt_reg  <= '0;
            w_loaded_reg <= 1'b0;
        end else begin
            if (rsp_hit) begin
                rsp_cnt_reg <= rsp_cnt_reg + CW'(1);
            end
            case (state_reg)
                IDLE: begin
                    if (first_load_i) begin
                        x_stride_reg <= x_stride_i;
                        w_stride_reg <= w_stride_i;
                        n_tiles_reg  <= n_tiles_i;
                        x_addr_reg   <= x_base_i;
                        w_addr_reg   <= w_base_i;
                        req_cnt_reg  <= '0;
                        rsp_cnt_reg  <= '0;
                        tile_idx_reg <= '0;
                        if (n_tiles_i == '0) begin
                            state_reg    <= HOLD;
                            w_loaded_reg <= 1'b1;
                        end else begin
                            state_reg <= LOAD_X;
                        end
                    end
                end
                LOAD_X, STREAM_X: begin
                    if (x_acc) begin
                        x_addr_reg <= x_addr_reg + x_stride_reg;
                        if (req_cnt_reg == X_LAST) begin
                            req_cnt_reg <= '0;
                            state_reg   <= (state_reg == LOAD_X) ? LOAD_W : STREAM_W;
                        end else begin
                            req_cnt_reg <= req_cnt_reg + CW'(1);
                        end
                    end
                end
                LOAD_W: begin
                    if (w_acc) begin
                        w_addr_reg <= w_addr_reg + w_stride_reg;
                        if (req_cnt_reg == W_LAST) begin
                            req_cnt_reg <= '0;
                            state_reg   <= WAIT_W;
                        end else begin
                            req_cnt_reg <= req_cnt_reg + CW'(1);
                        end
                    end
                end
                WAIT_W: begin
                    if (rsp_done) begin
                        w_loaded_reg <= 1'b1;
                        if (n_tiles_reg > CntWidth'(1)) begin
                            tile_idx_reg <= CntWidth'(1);
                            state_reg    <= STREAM_X;
                        end else begin
                            state_reg <= HOLD;
                        end
                    end
                end
                STREAM_W: begin
                    if (w_acc) begin
                        w_addr_reg <= w_addr_reg + w_stride_reg;
                        if (req_cnt_reg == W_LAST) begin
                            req_cnt_reg  <= '0;
                            tile_idx_reg <= tile_inc;
                            state_reg    <= (tile_inc == n_tiles_reg) ? HOLD : STREAM_X;
                        end else begin
                            req_cnt_reg <= req_cnt_reg + CW'(1);
                        end
                    end
                end
                HOLD: begin
                end
                default: state_reg <= IDLE;
            endcase
            // Abort wins over any same-cycle progress; an accept this cycle still counted as issued.
            if (job_end) begin
                state_reg    <= IDLE;
                w_loaded_reg <= 1'b0;
                tile_idx_reg <= '0;
                req_cnt_reg  <= '0;
                rsp_cnt_reg  <= '0;
            end
        end
    end

`ifdef REDMULE_LDSEQ_PERF_EN
    logic [31:0] stall_cnt_reg;
    logic        stall;

    assign stall = (x_req_valid_o && !x_req_ready_i) || (w_req_valid_o && !w_req_ready_i);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == IDLE) && first_load_i && (n_tiles_i != '0)) begin
            stall_cnt_reg <= '0;
        end else if (stall && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_redmule_load_sequencer.sv
// Bench for redmule_load_sequencer: per-job request list and preload/tile progress model,
// randomized readiness and config noise, directed abort/clear/wrap/zero-tile cases.
module tb_redmule_load_sequencer;

    localparam int H    = 4;
    localparam int TILE = 16;
`ifdef REDMULE_LDSEQ_PERF_EN
    localparam int STALL_EXP = 5;
`else
    localparam int STALL_EXP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, clear, first_load, sched_rst, finished;
    logic [15:0] n_tiles;
    logic [31:0] x_base, x_stride, w_base, w_stride;
    logic        x_req_valid, x_req_ready, w_req_valid, w_req_ready, w_rsp_valid;
    logic [31:0] x_req_addr, w_req_addr, stall_cnt;
    logic        w_loaded, busy;
    logic [15:0] tile_idx;

    always #5 clk = ~clk;

    redmule_load_sequencer dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_i       (clear),
        .first_load_i  (first_load),
        .sched_rst_i   (sched_rst),
        .finished_i    (finished),
        .n_tiles_i     (n_tiles),
        .x_base_i      (x_base),
        .x_stride_i    (x_stride),
        .w_base_i      (w_base),
        .w_stride_i    (w_stride),
        .x_req_valid_o (x_req_valid),
        .x_req_ready_i (x_req_ready),
        .x_req_addr_o  (x_req_addr),
        .w_req_valid_o (w_req_valid),
        .w_req_ready_i (w_req_ready),
        .w_req_addr_o  (w_req_addr),
        .w_rsp_valid_i (w_rsp_valid),
        .w_loaded_o    (w_loaded),
        .tile_idx_o    (tile_idx),
        .busy_o        (busy),
        .stall_cnt_o   (stall_cnt)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: ordered list of {is_w, addr} the job must issue, plus progress state.
    logic [32:0] exp_q[$];
    logic [31:0] x_seen[$];
    bit          loaded_exp, loaded_known, abort_pending, mon_en;
    int          tile_exp, rsp_seen, w_cnt, n_job;
    bit          p0v, p0p, p1v, p1p;
    bit          x_hold, w_hold;
    logic [31:0] x_prev, w_prev;

    task automatic start_job(input logic [31:0] xb, input logic [31:0] xs, input logic [31:0] wb,
                             input logic [31:0] ws, input int n, input bit check_lat);
        logic [31:0] a;
        exp_q.delete();
        x_seen.delete();
        for (int t = 0; t < n; t++) begin
            for (int i = 0; i < H; i++) begin
                a = xb + 32'(t * H + i) * xs;
                exp_q.push_back({1'b0, a});
            end
            for (int j = 0; j < TILE; j++) begin
                a = wb + 32'(t * TILE + j) * ws;
                exp_q.push_back({1'b1, a});
            end
        end
        n_job        = n;
        loaded_exp   = (n == 0);
        loaded_known = (n != 0);
        tile_exp     = 0;
        rsp_seen     = 0;
        w_cnt        = 0;
        @(posedge clk); #1;
        first_load = 1'b1;
        n_tiles    = 16'(n);
        x_base     = xb;
        x_stride   = xs;
        w_base     = wb;
        w_stride   = ws;
        if (check_lat) begin
            @(negedge clk);
            check("x_lat0", 64'(x_req_valid), 64'd0);
        end
        @(posedge clk); #1;
        first_load = 1'b0;
        if (check_lat) begin
            @(negedge clk);
            check("x_lat1", 64'(x_req_valid), 64'd1);
            check("x_addr0", 64'(x_req_addr), 64'(xb));
        end
    endtask

    task automatic wait_done(input int mode);
        int c;
        int stall_left = 5;
        bit stall_on = 1'b0;
        int final_tile = (n_job > 1) ? n_job : 0;
        for (c = 0; c < 3000; c++) begin
            if (exp_q.size() == 0 && loaded_exp && tile_exp == final_tile) break;
            @(posedge clk); #1;
            case (mode)
                1: begin
                    x_req_ready = ($urandom_range(3) != 0);
                    w_req_ready = ($urandom_range(3) != 0);
                    if ($urandom_range(7) == 0) begin
                        first_load = 1'b1;
                        n_tiles    = 16'($urandom);
                        x_base     = $urandom;
                        w_base     = $urandom;
                        x_stride   = $urandom;
                        w_stride   = $urandom;
                    end else begin
                        first_load = 1'b0;
                    end
                end
                2: begin
                    x_req_ready = 1'b1;
                    if (!stall_on && w_cnt >= 3) stall_on = 1'b1;
                    if (stall_on && stall_left > 0) begin
                        w_req_ready = 1'b0;
                        stall_left--;
                    end else begin
                        w_req_ready = 1'b1;
                    end
                end
                default: begin
                    x_req_ready = 1'b1;
                    w_req_ready = 1'b1;
                end
            endcase
        end
        check("job_done", 64'(c < 3000), 64'd1);
        first_load  = 1'b0;
        x_req_ready = 1'b1;
        w_req_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hold_busy", 64'(busy), 64'd1);
        check("hold_xv", 64'(x_req_valid), 64'd0);
        check("hold_wv", 64'(w_req_valid), 64'd0);
        check("hold_loaded", 64'(w_loaded), 64'd1);
        check("hold_tile", 64'(tile_idx), 64'(final_tile));
        if (mode != 1) check("stall_cnt", 64'(stall_cnt), (mode == 2) ? 64'(STALL_EXP) : 64'd0);
    endtask

    task automatic do_abort(input int kind);
        @(posedge clk); #1;
        case (kind)
            0:       sched_rst = 1'b1;
            1:       finished  = 1'b1;
            default: clear     = 1'b1;
        endcase
        abort_pending = 1'b1;
        @(posedge clk); #1;
        sched_rst = 1'b0;
        finished  = 1'b0;
        clear     = 1'b0;
        @(negedge clk);
        check("ab_busy", 64'(busy), 64'd0);
        check("ab_loaded", 64'(w_loaded), 64'd0);
        check("ab_tile", 64'(tile_idx), 64'd0);
        check("ab_xv", 64'(x_req_valid), 64'd0);
        check("ab_wv", 64'(w_req_valid), 64'd0);
        if (kind == 2) begin
            check("clr_xaddr", 64'(x_req_addr), 64'd0);
            check("clr_waddr", 64'(w_req_addr), 64'd0);
            check("clr_stall", 64'(stall_cnt), 64'd0);
        end
    endtask

    initial begin
        logic [32:0] e;
        int c;
        rst = 1'b1; clear = 1'b0; first_load = 1'b0; sched_rst = 1'b0; finished = 1'b0;
        n_tiles = '0; x_base = '0; x_stride = '0; w_base = '0; w_stride = '0;
        x_req_ready = 1'b1; w_req_ready = 1'b1; w_rsp_valid = 1'b0;
        loaded_exp = 1'b0; loaded_known = 1'b1; abort_pending = 1'b0; mon_en = 1'b0;
        tile_exp = 0; rsp_seen = 0; w_cnt = 0; n_job = 0;
        p0v = 0; p0p = 0; p1v = 0; p1p = 0; x_hold = 0; w_hold = 0; x_prev = '0; w_prev = '0;

        // Monitor: per-cycle protocol/progress checks, request scoreboard, response generator.
        fork
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    check("xw_excl", 64'(x_req_valid && w_req_valid), 64'd0);
                    if (x_hold) check("x_hold", {31'd0, x_req_valid, x_req_addr}, {31'd0, 1'b1, x_prev});
                    if (w_hold) check("w_hold", {31'd0, w_req_valid, w_req_addr}, {31'd0, 1'b1, w_prev});
                    if (loaded_known) check("w_loaded", 64'(w_loaded), 64'(loaded_exp));
                    check("tile_idx", 64'(tile_idx), 64'(tile_exp));
                    if (x_req_valid && x_req_ready) begin
                        $display("[TB] X req addr=0x%08h", x_req_addr);
                        x_seen.push_back(x_req_addr);
                        if (exp_q.size() == 0) check("extra_x", 64'd1, 64'd0);
                        else begin
                            e = exp_q.pop_front();
                            check("x_req", 64'({1'b0, x_req_addr}), 64'(e));
                        end
                    end
                    if (w_req_valid && w_req_ready) begin
                        $display("[TB] W req addr=0x%08h", w_req_addr);
                        w_cnt++;
                        if (exp_q.size() == 0) check("extra_w", 64'd1, 64'd0);
                        else begin
                            e = exp_q.pop_front();
                            check("w_req", 64'({1'b1, w_req_addr}), 64'(e));
                        end
                        if (w_cnt > TILE && (w_cnt % TILE) == 0) tile_exp = w_cnt / TILE;
                    end
                    p1v = p0v; p1p = p0p;
                    p0v = w_req_valid && w_req_ready;
                    p0p = (w_cnt <= TILE);
                    w_rsp_valid = p1v;
                    if (p1v && p1p) begin
                        rsp_seen++;
                        if (rsp_seen == TILE) begin
                            loaded_exp = 1'b1;
                            if (n_job > 1) tile_exp = 1;
                        end
                    end
                    x_hold = x_req_valid && !x_req_ready;
                    x_prev = x_req_addr;
                    w_hold = w_req_valid && !w_req_ready;
                    w_prev = w_req_addr;
                    if (abort_pending) begin
                        exp_q.delete();
                        loaded_exp = 1'b0; loaded_known = 1'b1;
                        tile_exp = 0; rsp_seen = 0; w_cnt = 0;
                        p0v = 0; p1v = 0; w_rsp_valid = 1'b0;
                        x_hold = 0; w_hold = 0;
                        abort_pending = 1'b0;
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_xv", 64'(x_req_valid), 64'd0);
        check("rst_wv", 64'(w_req_valid), 64'd0);
        check("rst_loaded", 64'(w_loaded), 64'd0);
        check("rst_tile", 64'(tile_idx), 64'd0);
        check("rst_xaddr", 64'(x_req_addr), 64'd0);
        check("rst_waddr", 64'(w_req_addr), 64'd0);
        check("rst_stall", 64'(stall_cnt), 64'd0);
        mon_en = 1'b1;

        // Single tile, ready tied high.
        start_job(32'h1000, 32'h40, 32'h8000, 32'h40, 1, 1'b1);
        wait_done(0);
        check("t1_xlast", 64'(x_seen.size() == 4 ? x_seen[3] : 32'hDEAD), 64'h10C0);
        do_abort(1);

        // Three tiles: addresses keep running across tiles.
        start_job(32'h1000, 32'h40, 32'h8000, 32'h40, 3, 1'b0);
        wait_done(0);
        check("t3_x4", 64'(x_seen.size() > 4 ? x_seen[4] : 32'hDEAD), 64'h1100);
        do_abort(0);

        // Five-cycle W stall in the middle of the preload.
        start_job(32'h1000, 32'h40, 32'h8000, 32'h40, 1, 1'b0);
        wait_done(2);
        do_abort(1);

        // Zero tiles: straight to hold with the preload flag up, no requests.
        start_job(32'h1000, 32'h40, 32'h8000, 32'h40, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("nt0_loaded", 64'(w_loaded), 64'd1);
        check("nt0_busy", 64'(busy), 64'd1);
        loaded_exp = 1'b1;
        loaded_known = 1'b1;
        repeat (8) @(negedge clk);
        check("nt0_noreq", 64'(x_seen.size()), 64'd0);
        do_abort(0);

        // Abort after seven W accepts, then restart from the bases.
        start_job(32'h1000, 32'h40, 32'h8000, 32'h40, 2, 1'b0);
        for (c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (w_cnt >= 7) begin
                w_req_ready = 1'b0;
                break;
            end
        end
        check("mid_reach", 64'(w_cnt), 64'd7);
        do_abort(0);
        w_req_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_xrows", 64'(x_seen.size()), 64'd4);
        check("mid_idle", 64'(busy), 64'd0);
        start_job(32'h1000, 32'h40, 32'h8000, 32'h40, 1, 1'b1);
        wait_done(0);
        do_abort(1);

        // Address wrap at 2^32.
        start_job(32'hFFFF_FFC0, 32'h40, 32'hFFFF_FF00, 32'h40, 2, 1'b0);
        wait_done(0);
        check("wrap_x1", 64'(x_seen.size() > 1 ? x_seen[1] : 32'hDEAD), 64'h0);
        do_abort(1);

        // Soft clear in the middle of streaming.
        start_job(32'h2000, 32'h10, 32'h9000, 32'h20, 3, 1'b0);
        for (c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            if (tile_exp >= 2) break;
        end
        check("clr_reach", 64'(tile_exp), 64'd2);
        do_abort(2);

        // Random jobs with random readiness and config noise.
        for (int j = 0; j < 8; j++) begin
            start_job($urandom, $urandom, $urandom, $urandom, int'($urandom_range(3, 1)), 1'b0);
            wait_done(1);
            do_abort(int'($urandom_range(2, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
